// File: rtl/shift_pkg.sv
// Shared definitions for the shift controller: operation codes, shift-register
// command codes, FSM states and small decode helpers.
package shift_pkg;

  localparam int SHIFT_DW = 32;

  // shift_op encodings
  localparam logic [2:0] OP_SLL  = 3'b000;
  localparam logic [2:0] OP_SRL  = 3'b001;
  localparam logic [2:0] OP_SRA  = 3'b010;
  localparam logic [2:0] OP_SLLV = 3'b011;
  localparam logic [2:0] OP_SRLV = 3'b100;
  localparam logic [2:0] OP_SRAV = 3'b101;

  // Commands understood by the external shift register
  typedef enum logic [2:0] {
    CMD_NOP         = 3'b000,
    CMD_LOAD        = 3'b001,
    CMD_LEFT        = 3'b010,
    CMD_RIGHT_LOG   = 3'b011,
    CMD_RIGHT_ARITH = 3'b100
  } cmd_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_CAPTURE,
    S_DONE
  } state_e;

  // Codes 110 and 111 have no meaning
  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= OP_SRAV);
  endfunction

  // Variable forms take the amount from rs_val[4:0]
  function automatic logic op_uses_rs(input logic [2:0] op);
    return (op == OP_SLLV) || (op == OP_SRLV) || (op == OP_SRAV);
  endfunction

  function automatic cmd_e op_to_cmd(input logic [2:0] op);
    cmd_e cmd;
    case (op)
      OP_SLL, OP_SLLV: cmd = CMD_LEFT;
      OP_SRL, OP_SRLV: cmd = CMD_RIGHT_LOG;
      OP_SRA, OP_SRAV: cmd = CMD_RIGHT_ARITH;
      default:         cmd = CMD_NOP;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/shift_ctrl_if.sv
// Request/result channel between a requester (master) and shift_ctrl (slave).
interface shift_ctrl_if
  import shift_pkg::*;
#(
  parameter int DW = SHIFT_DW
);
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    shift_op;
  logic [4:0]    shamt;
  logic [DW-1:0] rs_val;
  logic [DW-1:0] rt_val;
  logic [DW-1:0] result;
  logic          result_valid;
  logic          result_ack;
  logic          illegal_op;

  modport master (
    output req_valid, shift_op, shamt, rs_val, rt_val, result_ack,
    input  req_ready, result, result_valid, illegal_op
  );

  modport slave (
    input  req_valid, shift_op, shamt, rs_val, rt_val, result_ack,
    output req_ready, result, result_valid, illegal_op
  );
endinterface

// File: rtl/shift_ctrl.sv
// Sequences one shift request through an external registered shift register:
// load the operand, issue one multi-bit shift, capture the output, hold it
// until the consumer acknowledges.
module shift_ctrl
  import shift_pkg::*;
#(
  parameter int DW = SHIFT_DW
) (
  input  logic          Clk,
  input  logic          reset,
  shift_ctrl_if.slave   bus,
  output logic [2:0]    des_funct,
  output logic [4:0]    des_n,
  output logic [DW-1:0] des_array,
  input  logic [DW-1:0] des_shifted
);

  state_e        state_reg;
  cmd_e          cmd_reg;
  cmd_e          des_funct_reg;
  logic [4:0]    des_n_reg;
  logic [DW-1:0] des_array_reg;
  logic [DW-1:0] result_reg;
  logic          result_valid_reg;
  logic          illegal_reg;
  logic          req_ready_reg;

  logic          accept;
  logic [4:0]    amount_next;

  // Only the low five bits of rs_val carry a shift amount
  logic unused_rs_bits;
  assign unused_rs_bits = ^bus.rs_val[DW-1:5];

  assign accept      = bus.req_valid && req_ready_reg;
  assign amount_next = op_uses_rs(bus.shift_op) ? bus.rs_val[4:0] : bus.shamt;

  // Control FSM; every output is a register updated alongside the state
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_reg        <= S_IDLE;
      cmd_reg          <= CMD_NOP;
      des_funct_reg    <= CMD_NOP;
      des_n_reg        <= '0;
      des_array_reg    <= '0;
      result_reg       <= '0;
      result_valid_reg <= 1'b0;
      illegal_reg      <= 1'b0;
      req_ready_reg    <= 1'b1;
    end else begin
      case (state_reg)
        S_IDLE: begin
          des_funct_reg <= CMD_NOP;
          if (accept) begin
            req_ready_reg <= 1'b0;
            if (op_is_legal(bus.shift_op)) begin
              illegal_reg   <= 1'b0;
              cmd_reg       <= op_to_cmd(bus.shift_op);
              des_n_reg     <= amount_next;
              des_array_reg <= bus.rt_val;
              des_funct_reg <= CMD_LOAD;
              state_reg     <= S_LOAD;
            end else begin
              // Nothing reaches the shift register for an illegal op
              illegal_reg      <= 1'b1;
              result_reg       <= '0;
              result_valid_reg <= 1'b1;
              state_reg        <= S_DONE;
            end
          end
        end
        S_LOAD: begin
          if (des_n_reg != 5'd0) begin
            des_funct_reg <= cmd_reg;
            state_reg     <= S_SHIFT;
          end else begin
            // Zero amount: the loaded value already is the answer
            des_funct_reg <= CMD_NOP;
            state_reg     <= S_CAPTURE;
          end
        end
        S_SHIFT: begin
          des_funct_reg <= CMD_NOP;
          state_reg     <= S_CAPTURE;
        end
        S_CAPTURE: begin
          des_funct_reg    <= CMD_NOP;
          result_reg       <= des_shifted;
          result_valid_reg <= 1'b1;
          state_reg        <= S_DONE;
        end
        S_DONE: begin
          des_funct_reg <= CMD_NOP;
          if (bus.result_ack) begin
            result_valid_reg <= 1'b0;
            req_ready_reg    <= 1'b1;
            state_reg        <= S_IDLE;
          end
        end
        default: begin
          des_funct_reg    <= CMD_NOP;
          result_valid_reg <= 1'b0;
          req_ready_reg    <= 1'b1;
          state_reg        <= S_IDLE;
        end
      endcase
    end
  end

  assign des_funct        = des_funct_reg;
  assign des_n            = des_n_reg;
  assign des_array        = des_array_reg;
  assign bus.req_ready    = req_ready_reg;
  assign bus.result       = result_reg;
  assign bus.result_valid = result_valid_reg;
  assign bus.illegal_op   = illegal_reg;

endmodule

// File: tb/tb_shift_ctrl.sv
// Bench for shift_ctrl: external shift-register model, a transaction-level
// reference model checked every cycle, and directed scenarios with
// hand-computed expectations.
module tb_shift_ctrl;

  logic        Clk;
  logic        reset;
  logic [2:0]  des_funct;
  logic [4:0]  des_n;
  logic [31:0] des_array;
  logic [31:0] des_shifted;

  shift_ctrl_if #(.DW(32)) bus ();

  shift_ctrl #(.DW(32)) dut (
    .Clk         (Clk),
    .reset       (reset),
    .bus         (bus),
    .des_funct   (des_funct),
    .des_n       (des_n),
    .des_array   (des_array),
    .des_shifted (des_shifted)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // External shift register, sharing the controller's reset
  logic [31:0] sr;
  always @(posedge Clk) begin
    if (reset) sr <= '0;
    else begin
      case (des_funct)
        3'd1: sr <= des_array;
        3'd2: sr <= sr << des_n;
        3'd3: sr <= sr >> des_n;
        3'd4: sr <= $signed(sr) >>> des_n;
        default: sr <= sr;
      endcase
    end
  end
  assign des_shifted = sr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: op mod 3 selects left / logical right / arithmetic right
  function automatic logic [31:0] golden(input logic [2:0] op, input logic [31:0] v, input logic [4:0] a);
    case (op % 3)
      0:       return v << a;
      1:       return v >> a;
      default: return $signed(v) >>> a;
    endcase
  endfunction

  // Transaction model: a countdown until the result appears, no FSM states
  logic        m_ready, m_valid, m_illegal;
  logic [31:0] m_result, m_pend, m_rt;
  logic [4:0]  m_amt;
  logic [2:0]  m_funct, m_cmd;
  int          m_left;

  always @(posedge Clk) begin
    logic [4:0] a;
    if (reset) begin
      m_ready <= 1'b1; m_valid <= 1'b0; m_illegal <= 1'b0;
      m_result <= '0; m_pend <= '0; m_rt <= '0; m_amt <= '0;
      m_funct <= 3'd0; m_cmd <= 3'd0; m_left <= 0;
    end else begin
      m_funct <= 3'd0;
      if (m_ready && bus.req_valid) begin
        m_ready <= 1'b0;
        if (bus.shift_op >= 3'd6) begin
          m_valid <= 1'b1; m_result <= '0; m_illegal <= 1'b1; m_left <= 0;
        end else begin
          a = (bus.shift_op >= 3'd3) ? bus.rs_val[4:0] : bus.shamt;
          m_illegal <= 1'b0;
          m_amt  <= a;
          m_rt   <= bus.rt_val;
          m_pend <= golden(bus.shift_op, bus.rt_val, a);
          m_cmd  <= 3'd2 + 3'(bus.shift_op % 3);
          m_left <= (a != 0) ? 3 : 2;
          m_funct <= 3'd1;
        end
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 3) m_funct <= m_cmd;
        if (m_left == 1) begin
          m_valid <= 1'b1; m_result <= m_pend;
        end
      end else if (m_valid && bus.result_ack) begin
        m_valid <= 1'b0; m_ready <= 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge Clk) begin
    if (chk_en) begin
      check("cyc_ready",   32'(bus.req_ready),    32'(m_ready));
      check("cyc_valid",   32'(bus.result_valid), 32'(m_valid));
      check("cyc_illegal", 32'(bus.illegal_op),   32'(m_illegal));
      check("cyc_result",  bus.result,            m_result);
      check("cyc_funct",   32'(des_funct),        32'(m_funct));
      check("cyc_des_n",   32'(des_n),            32'(m_amt));
      check("cyc_array",   des_array,             m_rt);
    end
  end

  logic [2:0] fseq[$];

  // Issue one request; report edges from accept (inclusive) to result_valid
  task automatic do_req(input logic [2:0] op, input logic [4:0] sh, input logic [31:0] rs,
                        input logic [31:0] rt, output int lat);
    int w;
    w = 0;
    while (!bus.req_ready && w < 20) begin
      @(posedge Clk); #1; w++;
    end
    if (!bus.req_ready) check("ready_timeout", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.shift_op = op; bus.shamt = sh; bus.rs_val = rs; bus.rt_val = rt;
    @(posedge Clk); #1;
    // Scramble request inputs: they must be ignored once accepted
    bus.req_valid = 1'b0; bus.shift_op = 3'd0; bus.shamt = 5'd31;
    bus.rs_val = 32'hFFFF_FFFF; bus.rt_val = 32'h1234_5678;
    fseq.delete();
    fseq.push_back(des_funct);
    lat = 1;
    while (!bus.result_valid && lat < 20) begin
      @(posedge Clk); #1; lat++;
      fseq.push_back(des_funct);
    end
    if (!bus.result_valid) check("valid_timeout", 32'(bus.result_valid), 32'd1);
    $display("[TB] req op=%0d shamt=%0d rs=0x%08h rt=0x%08h -> result=0x%08h illegal=%0d latency=%0d",
             op, sh, rs, rt, bus.result, bus.illegal_op, lat);
  endtask

  task automatic do_ack();
    bus.result_ack = 1'b1;
    @(posedge Clk); #1;
    bus.result_ack = 1'b0;
    check("ack_ready", 32'(bus.req_ready), 32'd1);
    check("ack_valid", 32'(bus.result_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.shift_op = 3'd0; bus.shamt = 5'd0;
    bus.rs_val = '0; bus.rt_val = '0; bus.result_ack = 1'b0;
    repeat (2) @(posedge Clk);
    #1 reset = 1'b0;
    chk_en = 1;
    check("rst_ready",   32'(bus.req_ready), 32'd1);
    check("rst_valid",   32'(bus.result_valid), 32'd0);
    check("rst_result",  bus.result, 32'd0);
    check("rst_funct",   32'(des_funct), 32'd0);

    // SLL 1 by 4
    do_req(3'd0, 5'd4, 32'h0, 32'h0000_0001, lat);
    check("sll_result", bus.result, 32'h0000_0010);
    check("sll_latency", 32'(lat), 32'd4);
    check("sll_f0", 32'(fseq[0]), 32'd1);
    check("sll_f1", 32'(fseq[1]), 32'd2);
    check("sll_f2", 32'(fseq[2]), 32'd0);
    do_ack();

    // SRAV with ack held high throughout: ack is ignored before DONE
    bus.result_ack = 1'b1;
    do_req(3'd5, 5'd0, 32'h0000_0021, 32'h8000_0000, lat);
    check("srav_result", bus.result, 32'hC000_0000);
    check("srav_latency", 32'(lat), 32'd4);
    @(posedge Clk); #1;
    bus.result_ack = 1'b0;
    check("srav_ready", 32'(bus.req_ready), 32'd1);
    check("srav_keep", bus.result, 32'hC000_0000);

    // SRL by zero: no shift command
    do_req(3'd1, 5'd0, 32'h0, 32'hDEAD_BEEF, lat);
    check("srl0_result", bus.result, 32'hDEAD_BEEF);
    check("srl0_latency", 32'(lat), 32'd3);
    check("srl0_f0", 32'(fseq[0]), 32'd1);
    check("srl0_f1", 32'(fseq[1]), 32'd0);
    do_ack();

    // Illegal op
    do_req(3'd7, 5'd3, 32'h0, 32'hFFFF_FFFF, lat);
    check("ill_flag", 32'(bus.illegal_op), 32'd1);
    check("ill_result", bus.result, 32'd0);
    check("ill_latency", 32'(lat), 32'd1);
    check("ill_f0", 32'(fseq[0]), 32'd0);
    do_ack();

    // SRLV 0xFF00 by 8, then hold ack low for 5 cycles
    do_req(3'd4, 5'd0, 32'h0000_0008, 32'h0000_FF00, lat);
    check("srlv_result", bus.result, 32'h0000_00FF);
    check("srlv_illegal", 32'(bus.illegal_op), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      check("hold_result", bus.result, 32'h0000_00FF);
      check("hold_ready", 32'(bus.req_ready), 32'd0);
      check("hold_valid", 32'(bus.result_valid), 32'd1);
    end
    do_ack();

    // Reset while in SHIFT: no result may appear
    bus.req_valid = 1'b1; bus.shift_op = 3'd0; bus.shamt = 5'd3; bus.rt_val = 32'h0000_0005;
    @(posedge Clk); #1;            // accepted, now LOAD
    bus.req_valid = 1'b0;
    @(posedge Clk); #1;            // now SHIFT
    check("abort_in_shift", 32'(des_funct), 32'd2);
    reset = 1'b1;
    @(posedge Clk); #1;
    reset = 1'b0;
    check("abort_ready", 32'(bus.req_ready), 32'd1);
    check("abort_valid", 32'(bus.result_valid), 32'd0);
    check("abort_result", bus.result, 32'd0);
    check("abort_funct", 32'(des_funct), 32'd0);
    check("abort_des_n", 32'(des_n), 32'd0);
    check("abort_array", des_array, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge Clk); #1;
      check("abort_no_valid", 32'(bus.result_valid), 32'd0);
    end
    $display("[TB] reset during SHIFT: result_valid=%0d result=0x%08h", bus.result_valid, bus.result);

    @(negedge Clk);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
